// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/stall controller:
// controller state encoding and load-use stall length limits.
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } state_e;

    // Largest number of load-use bubbles representable by the 3-bit countdown.
    localparam int unsigned LU_STALL_MAX = 7;
    localparam int unsigned LU_LEFT_W    = 3;

endpackage

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear and synchronous reset.
// Clear takes precedence over increment; the count sticks at all-ones.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear, saturating increment, or hold.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Five-stage pipeline stall/flush controller.
// Responds combinationally (same cycle) to mem_busy > branch_taken >
// fetch_nop_LD and sequences multi-cycle load-use stalls and memory waits.
// Optional build macro HAZ_PERF_CNT_EN adds three saturating performance
// counters; without it the counter outputs are tied to zero.
module pipeline_stall_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned LU_STALL_CYCLES = 1,
    parameter int unsigned PERF_CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fetch_nop_LD,
    input  logic                  branch_taken,
    input  logic                  mem_busy,
    input  logic                  perf_clr,
    output logic                  pc_en,
    output logic                  ifid_en,
    output logic                  ifid_flush,
    output logic                  idex_en,
    output logic                  idex_bubble,
    output logic                  exmem_en,
    output logic                  memwb_bubble,
    output logic                  stall_active,
    output logic [PERF_CNT_W-1:0] lu_cnt,
    output logic [PERF_CNT_W-1:0] flush_cnt,
    output logic [PERF_CNT_W-1:0] memwait_cnt
);

    // Remaining LU_STALL cycles after the initial load-use response cycle.
    localparam logic [LU_LEFT_W-1:0] LU_INIT = LU_LEFT_W'(LU_STALL_CYCLES - 1);

    state_e               state_q, state_d;
    state_e               ret_state_q, ret_state_d;
    logic [LU_LEFT_W-1:0] lu_left_q, lu_left_d;

    logic lu_ev;
    logic flush_ev;
    logic memwait_ev;

    // Mealy outputs and next-state selection, priority mem_busy > branch > load-use.
    always_comb begin
        state_d      = state_q;
        ret_state_d  = ret_state_q;
        lu_left_d    = lu_left_q;
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        ifid_flush   = 1'b0;
        idex_en      = 1'b1;
        idex_bubble  = 1'b0;
        exmem_en     = 1'b1;
        memwb_bubble = 1'b0;
        lu_ev        = 1'b0;
        flush_ev     = 1'b0;
        memwait_ev   = 1'b0;

        if (mem_busy) begin
            // Freeze the front of the pipe and drain a bubble into MEM/WB.
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_en      = 1'b0;
            exmem_en     = 1'b0;
            memwb_bubble = 1'b1;
            memwait_ev   = 1'b1;
            if (state_q != MEM_WAIT) begin
                ret_state_d = state_q;
                state_d     = MEM_WAIT;
            end
        end else if (branch_taken) begin
            // Flush squashes any load-use victim, so the sequence is aborted.
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            flush_ev    = 1'b1;
            state_d     = RUN;
            lu_left_d   = '0;
        end else if (state_q == LU_STALL) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_bubble = 1'b1;
            lu_ev       = 1'b1;
            if (lu_left_q <= LU_LEFT_W'(1)) begin
                lu_left_d = '0;
                state_d   = RUN;
            end else begin
                lu_left_d = lu_left_q - 1'b1;
            end
        end else begin
            // RUN, or the release cycle of MEM_WAIT evaluated with RUN rules.
            if (state_q == MEM_WAIT) begin
                state_d = ret_state_q;
            end
            if (fetch_nop_LD) begin
                pc_en       = 1'b0;
                ifid_en     = 1'b0;
                idex_bubble = 1'b1;
                lu_ev       = 1'b1;
                if (LU_STALL_CYCLES > 1) begin
                    state_d   = LU_STALL;
                    lu_left_d = LU_INIT;
                end
            end
        end

        stall_active = ~(pc_en & ifid_en & idex_en & exmem_en)
                     | ifid_flush | idex_bubble | memwb_bubble;

        if (rst) begin
            // Hold every stage and force NOPs while reset is applied.
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            ifid_flush   = 1'b1;
            idex_en      = 1'b0;
            idex_bubble  = 1'b1;
            exmem_en     = 1'b0;
            memwb_bubble = 1'b1;
            stall_active = 1'b0;
            lu_ev        = 1'b0;
            flush_ev     = 1'b0;
            memwait_ev   = 1'b0;
        end
    end

    // State, return-state and load-use countdown registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            ret_state_q <= RUN;
            lu_left_q   <= '0;
        end else begin
            state_q     <= state_d;
            ret_state_q <= ret_state_d;
            lu_left_q   <= lu_left_d;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    sat_counter #(.W(PERF_CNT_W)) u_lu_cnt (
        .clk (clk),
        .rst (rst),
        .inc (lu_ev),
        .clr (perf_clr),
        .cnt (lu_cnt)
    );

    sat_counter #(.W(PERF_CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (flush_ev),
        .clr (perf_clr),
        .cnt (flush_cnt)
    );

    sat_counter #(.W(PERF_CNT_W)) u_memwait_cnt (
        .clk (clk),
        .rst (rst),
        .inc (memwait_ev),
        .clr (perf_clr),
        .cnt (memwait_cnt)
    );
`else
    logic unused_perf;
    assign unused_perf = ^{lu_ev, flush_ev, memwait_ev, perf_clr};

    assign lu_cnt      = '0;
    assign flush_cnt   = '0;
    assign memwait_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed testbench for pipeline_stall_ctrl. Two instances share stimulus:
// d1 with one load-use bubble, d3 with three bubbles and 4-bit counters.
module tb_pipeline_stall_ctrl;

    logic clk = 1'b0;
    logic rst, fetch_nop_LD, branch_taken, mem_busy, perf_clr;

    logic pc_en1, ifid_en1, ifid_flush1, idex_en1, idex_bubble1, exmem_en1, memwb_bubble1, stall_active1;
    logic [3:0] lu_cnt1, flush_cnt1, memwait_cnt1;
    logic pc_en3, ifid_en3, ifid_flush3, idex_en3, idex_bubble3, exmem_en3, memwb_bubble3, stall_active3;
    logic [3:0] lu_cnt3, flush_cnt3, memwait_cnt3;

    int checks = 0;
    int errors = 0;

    // Output vector order: pc_en ifid_en ifid_flush idex_en idex_bubble exmem_en memwb_bubble stall_active
    localparam logic [7:0] V_RUN   = 8'b1101_0100;
    localparam logic [7:0] V_LU    = 8'b0001_1101;
    localparam logic [7:0] V_FLUSH = 8'b1111_1101;
    localparam logic [7:0] V_MEMB  = 8'b0000_0011;
    localparam logic [7:0] V_RST   = 8'b0010_1010;

    always #5 clk = ~clk;

    pipeline_stall_ctrl #(.LU_STALL_CYCLES(1), .PERF_CNT_W(4)) d1 (
        .clk(clk), .rst(rst), .fetch_nop_LD(fetch_nop_LD), .branch_taken(branch_taken),
        .mem_busy(mem_busy), .perf_clr(perf_clr),
        .pc_en(pc_en1), .ifid_en(ifid_en1), .ifid_flush(ifid_flush1), .idex_en(idex_en1),
        .idex_bubble(idex_bubble1), .exmem_en(exmem_en1), .memwb_bubble(memwb_bubble1),
        .stall_active(stall_active1), .lu_cnt(lu_cnt1), .flush_cnt(flush_cnt1),
        .memwait_cnt(memwait_cnt1)
    );

    pipeline_stall_ctrl #(.LU_STALL_CYCLES(3), .PERF_CNT_W(4)) d3 (
        .clk(clk), .rst(rst), .fetch_nop_LD(fetch_nop_LD), .branch_taken(branch_taken),
        .mem_busy(mem_busy), .perf_clr(perf_clr),
        .pc_en(pc_en3), .ifid_en(ifid_en3), .ifid_flush(ifid_flush3), .idex_en(idex_en3),
        .idex_bubble(idex_bubble3), .exmem_en(exmem_en3), .memwb_bubble(memwb_bubble3),
        .stall_active(stall_active3), .lu_cnt(lu_cnt3), .flush_cnt(flush_cnt3),
        .memwait_cnt(memwait_cnt3)
    );

    wire [7:0] v1 = {pc_en1, ifid_en1, ifid_flush1, idex_en1, idex_bubble1, exmem_en1, memwb_bubble1, stall_active1};
    wire [7:0] v3 = {pc_en3, ifid_en3, ifid_flush3, idex_en3, idex_bubble3, exmem_en3, memwb_bubble3, stall_active3};

    // Expected counter value: counters exist only when the feature is built.
    function automatic logic [3:0] cexp(input int v);
`ifdef HAZ_PERF_CNT_EN
        return 4'(v);
`else
        return (v == v) ? 4'd0 : 4'd0;
`endif
    endfunction

    // Apply one cycle of inputs after the falling edge; outputs settle 1 ns later.
    task automatic step(input logic r, input logic ld, input logic br, input logic mb, input logic pc);
        @(negedge clk);
        rst          = r;
        fetch_nop_LD = ld;
        branch_taken = br;
        mem_busy     = mb;
        perf_clr     = pc;
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
        $display("check %-14s observed=%b expected=%b", tag, obs, exp);
    endtask

    initial begin
        rst = 1'b1; fetch_nop_LD = 1'b0; branch_taken = 1'b0; mem_busy = 1'b0; perf_clr = 1'b0;

        // Reset state
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("rst_out3", v3, V_RST);
        chk("rst_out1", v1, V_RST);
        chk("rst_lucnt", {4'd0, lu_cnt3}, {4'd0, cexp(0)});
        step(0, 0, 0, 0, 0);
        chk("idle_run3", v3, V_RUN);
        chk("idle_run1", v1, V_RUN);

        // Single load-use pulse, N=1
        step(0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0);
        chk("lu1_resp", v1, V_LU);
        step(0, 0, 0, 0, 0);
        chk("lu1_back", v1, V_RUN);
        chk("lu1_cnt", {4'd0, lu_cnt1}, {4'd0, cexp(1)});
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);

        // N=3: pc_en low for exactly three cycles
        step(0, 1, 0, 0, 0);
        chk("lu3_c0", v3, V_LU);
        step(0, 0, 0, 0, 0);
        chk("lu3_c1", v3, V_LU);
        step(0, 0, 0, 0, 0);
        chk("lu3_c2", v3, V_LU);
        step(0, 0, 0, 0, 0);
        chk("lu3_c3_run", v3, V_RUN);

        // N=3 with branch in the second cycle
        step(0, 1, 0, 0, 0);
        chk("lubr_c0", v3, V_LU);
        step(0, 0, 1, 0, 0);
        chk("lubr_flush", v3, V_FLUSH);
        step(0, 0, 0, 0, 0);
        chk("lubr_run", v3, V_RUN);

        // Load-use and branch together
        step(0, 0, 0, 0, 1);
        step(0, 1, 1, 0, 0);
        chk("ldbr_flush", v3, V_FLUSH);
        step(0, 0, 0, 0, 0);
        chk("ldbr_run", v3, V_RUN);
        chk("ldbr_lucnt", {4'd0, lu_cnt3}, {4'd0, cexp(0)});
        chk("ldbr_flcnt", {4'd0, flush_cnt3}, {4'd0, cexp(1)});

        // mem_busy for 4 cycles while LU_STALL has one cycle left
        step(0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0);
        chk("mw_lu0", v3, V_LU);
        step(0, 0, 0, 0, 0);
        chk("mw_lu1", v3, V_LU);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 1, 0);
            chk($sformatf("mw_busy%0d", i), v3, V_MEMB);
        end
        step(0, 0, 0, 0, 0);
        chk("mw_release", v3, V_RUN);
        step(0, 0, 0, 0, 0);
        chk("mw_lastlu", v3, V_LU);
        step(0, 0, 0, 0, 0);
        chk("mw_run", v3, V_RUN);
        chk("mw_mwcnt", {4'd0, memwait_cnt3}, {4'd0, cexp(4)});
        chk("mw_lucnt", {4'd0, lu_cnt3}, {4'd0, cexp(3)});

        // Reset asserted during MEM_WAIT
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        chk("rmw_busy", v3, V_MEMB);
        step(1, 0, 0, 1, 0);
        chk("rmw_rstout", v3, V_RST);
        step(0, 0, 0, 0, 0);
        chk("rmw_run", v3, V_RUN);
        chk("rmw_lucnt", {4'd0, lu_cnt3}, {4'd0, cexp(0)});
        chk("rmw_mwcnt", {4'd0, memwait_cnt3}, {4'd0, cexp(0)});
        step(0, 1, 0, 0, 0);
        chk("rmw_newlu", v3, V_LU);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("rmw_newrun", v3, V_RUN);

        // Saturation of flush_cnt at 15, then clear beats increment
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 1, 0, 0);
        end
        chk("sat_flush_out", v3, V_FLUSH);
        step(0, 0, 1, 0, 1);
        chk("sat_flcnt", {4'd0, flush_cnt3}, {4'd0, cexp(15)});
        step(0, 0, 0, 0, 0);
        chk("clr_flcnt", {4'd0, flush_cnt3}, {4'd0, cexp(0)});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
